// File: rtl/zx_key_reporter.sv
// rtl/zx_key_reporter.sv - scans 31 keys and reports each change as a UART scan-code frame
// Optional macro BREAK_CODE_EN: a release sends an F0 prefix frame before the key code.
module zx_key_reporter #(
    parameter int CLK_HZ = 27000000,
    parameter int BAUD   = 115200
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [39:0] keys,
    output logic        txd,
    output logic        busy,
    output logic        byte_done
);

    localparam int BIT_PERIOD = CLK_HZ / BAUD;
    localparam int BW         = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BIT_PERIOD - 1);

`ifdef BREAK_CODE_EN
    typedef enum logic [1:0] {SCAN = 2'd0, PREFIX = 2'd1, CODE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {SCAN = 2'd0, CODE = 2'd2} state_t;
`endif

    state_t        state_q, state_d;
    logic [4:0]    idx_q, idx_d;
    logic [30:0]   prev_q, prev_d;
    logic [7:0]    shift_q, shift_d;
    logic [3:0]    bit_q, bit_d;
    logic [BW-1:0] baud_q, baud_d;
    logic          txd_q, txd_d;
`ifdef BREAK_CODE_EN
    logic [7:0]    code_q, code_d;
`endif

    logic          last_tick;
    logic          key_now;
    logic          unused_keys;

    assign unused_keys = ^keys[39:31];

    function automatic logic [7:0] key_code(input logic [4:0] i);
        case (i)
            5'd0:    key_code = 8'h15;
            5'd1:    key_code = 8'h1D;
            5'd2:    key_code = 8'h24;
            5'd3:    key_code = 8'h2D;
            5'd4:    key_code = 8'h2C;
            5'd5:    key_code = 8'h1C;
            5'd6:    key_code = 8'h1B;
            5'd7:    key_code = 8'h23;
            5'd8:    key_code = 8'h2B;
            5'd9:    key_code = 8'h34;
            5'd10:   key_code = 8'h1A;
            5'd11:   key_code = 8'h22;
            5'd12:   key_code = 8'h21;
            5'd13:   key_code = 8'h2A;
            5'd14:   key_code = 8'h32;
            5'd15:   key_code = 8'h16;
            5'd16:   key_code = 8'h1E;
            5'd17:   key_code = 8'h26;
            5'd18:   key_code = 8'h25;
            5'd19:   key_code = 8'h2E;
            5'd20:   key_code = 8'h36;
            5'd21:   key_code = 8'h3D;
            5'd22:   key_code = 8'h3E;
            5'd23:   key_code = 8'h46;
            5'd24:   key_code = 8'h45;
            5'd25:   key_code = 8'h12;
            5'd26:   key_code = 8'h59;
            5'd27:   key_code = 8'h14;
            5'd28:   key_code = 8'h11;
            5'd29:   key_code = 8'h29;
            5'd30:   key_code = 8'h5A;
            default: key_code = 8'h00;
        endcase
    endfunction

    assign last_tick = (baud_q == BAUD_LAST);
    assign key_now   = keys[idx_q];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        prev_d  = prev_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        txd_d   = txd_q;
`ifdef BREAK_CODE_EN
        code_d  = code_q;
`endif
        case (state_q)
            SCAN: begin
                txd_d = 1'b1;
                idx_d = (idx_q == 5'd30) ? 5'd0 : idx_q + 5'd1;
                if (key_now != prev_q[idx_q]) begin
                    // Start bit goes out on the very next clock.
                    prev_d[idx_q] = key_now;
                    bit_d         = 4'd0;
                    baud_d        = '0;
                    txd_d         = 1'b0;
                    state_d       = CODE;
                    shift_d       = key_code(idx_q);
`ifdef BREAK_CODE_EN
                    code_d        = key_code(idx_q);
                    if (!key_now) begin
                        state_d = PREFIX;
                        shift_d = 8'hF0;
                    end
`endif
                end
            end
            default: begin
                if (last_tick) begin
                    baud_d = '0;
                    if (bit_q == 4'd9) begin
                        bit_d = 4'd0;
`ifdef BREAK_CODE_EN
                        if (state_q == PREFIX) begin
                            // Code frame follows the prefix stop bit with no idle gap.
                            state_d = CODE;
                            shift_d = code_q;
                            txd_d   = 1'b0;
                        end else begin
                            state_d = SCAN;
                            txd_d   = 1'b1;
                        end
`else
                        state_d = SCAN;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 4'd1;
                        if (bit_q == 4'd8) begin
                            txd_d = 1'b1;
                        end else begin
                            txd_d   = shift_q[0];
                            shift_d = {1'b0, shift_q[7:1]};
                        end
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SCAN;
            idx_q   <= 5'd0;
            prev_q  <= '0;
            shift_q <= '0;
            bit_q   <= 4'd0;
            baud_q  <= '0;
            txd_q   <= 1'b1;
`ifdef BREAK_CODE_EN
            code_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            prev_q  <= prev_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
            txd_q   <= txd_d;
`ifdef BREAK_CODE_EN
            code_q  <= code_d;
`endif
        end
    end

    assign txd       = txd_q;
    assign busy      = (state_q != SCAN);
    assign byte_done = busy && (bit_q == 4'd9) && last_tick;

endmodule

// File: tb/tb_zx_key_reporter.sv
// tb/tb_zx_key_reporter.sv - scoreboard bench: stimulus queues expected bytes, UART monitor decodes and compares
module tb_zx_key_reporter;

    localparam int BP    = 27000000 / 115200;
    localparam int FRAME = 10 * BP;

    logic        clk;
    logic        reset_n;
    logic [39:0] keys;
    logic        txd;
    logic        busy;
    logic        byte_done;

    int n_cmp = 0;
    int n_err = 0;
    int frames_seen = 0;
    int exp_frames = 0;
    bit in_frame = 0;
    logic [7:0] exp_q[$];

    zx_key_reporter #(.CLK_HZ(27000000), .BAUD(115200)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .keys      (keys),
        .txd       (txd),
        .busy      (busy),
        .byte_done (byte_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        exp_q.push_back(b);
        exp_frames++;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(exp_q.size() == 0 && !in_frame && !busy) && t < 30000);
        if (t >= 30000) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idle: timeout with %0d frames pending, expected 0", exp_q.size());
        end
    endtask

    task automatic check_frames(input string name);
        repeat (300) @(negedge clk);
        check(name, frames_seen, exp_frames);
    endtask

    // UART monitor: decodes each frame, checks framing, byte_done timing and busy
    initial begin
        logic       last;
        logic [7:0] rx;
        logic       start_b, stop_b, bd_ok, busy_ok, abort;
        logic [7:0] exp;
        last = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                last = 1'b1;
                continue;
            end
            if (byte_done) begin
                n_cmp++;
                n_err++;
                $display("FAIL stray_byte_done: got 1 expected 0");
            end
            if (last && !txd) begin
                in_frame = 1;
                abort    = 0;
                rx       = '0;
                start_b  = 1'b0;
                stop_b   = 1'b0;
                bd_ok    = 1'b1;
                busy_ok  = busy;
                for (int c = 1; c < FRAME; c++) begin
                    @(negedge clk);
                    if (!reset_n) begin
                        abort = 1;
                        break;
                    end
                    if (c % BP == BP / 2) begin
                        if (c / BP == 0) start_b = txd;
                        else if (c / BP == 9) stop_b = txd;
                        else rx[c / BP - 1] = txd;
                    end
                    if (byte_done != (c == FRAME - 1)) bd_ok = 1'b0;
                    if (!busy) busy_ok = 1'b0;
                end
                in_frame = 0;
                last = 1'b1;
                if (abort) continue;
                frames_seen++;
                check("framing_start_stop", {start_b, stop_b}, 2'b01);
                check("byte_done_timing", bd_ok, 1'b1);
                check("busy_in_frame", busy_ok, 1'b1);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_frame: got %0h expected none", rx);
                end else begin
                    exp = exp_q.pop_front();
                    check("frame_byte", rx, exp);
                end
            end else begin
                last = txd;
            end
        end
    end

    initial begin
        int bad;
        keys    = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txd", txd, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_byte_done", byte_done, 1'b0);
        reset_n = 1'b1;

        bad = 0;
        repeat (5000) begin
            @(negedge clk);
            if (!txd || busy || byte_done) bad++;
        end
        check("idle_5000", bad, 0);

        keys[0] = 1'b1;
        push(8'h15);
        wait_idle();
        check_frames("press_k0");

        keys[30] = 1'b1;
        push(8'h5A);
        wait_idle();
        check_frames("press_k30");

        // Release 30, then raise 5 and 29 together while busy; scan resumes at index 0
        keys[30] = 1'b0;
`ifdef BREAK_CODE_EN
        push(8'hF0);
`endif
        push(8'h5A);
        repeat (100) @(negedge clk);
        check("busy_during_release", busy, 1'b1);
        keys[5]  = 1'b1;
        keys[29] = 1'b1;
        push(8'h1C);
        push(8'h29);
        wait_idle();
        check_frames("simul_5_29");

        // Key 2 pulsed entirely inside a busy window, key 35 unmapped
        keys[0] = 1'b0;
`ifdef BREAK_CODE_EN
        push(8'hF0);
`endif
        push(8'h15);
        repeat (100) @(negedge clk);
        keys[2]  = 1'b1;
        keys[35] = 1'b1;
        repeat (100) @(negedge clk);
        keys[2] = 1'b0;
        wait_idle();
        check_frames("pulse_k2");
        keys[35] = 1'b0;
        repeat (50) @(negedge clk);
        keys[35] = 1'b1;
        repeat (50) @(negedge clk);
        keys[35] = 1'b0;
        check_frames("unmapped_k35");

        // Reset in the middle of a frame
        keys[0] = 1'b1;
        bad = 0;
        while (!busy && bad < 100) begin
            @(negedge clk);
            bad++;
        end
        check("busy_before_abort", busy, 1'b1);
        repeat (1000) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_txd", txd, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_byte_done", byte_done, 1'b0);
        repeat (5) @(negedge clk);
        push(8'h15);
        push(8'h1C);
        push(8'h29);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_start_txd", txd, 1'b0);
        check("post_reset_start_busy", busy, 1'b1);
        wait_idle();
        check_frames("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/zx_key_reporter.md
ZX_KEY_REPORTER -- requirements
Module: zx_key_reporter

Interface
REQ-001 Parameter CLK_HZ, default 27000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, UART bit rate.
REQ-003 Port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 Port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port keys  input  40  key state, 1 = pressed, synchronous to clk; bits 31-39 are unmapped and SHALL be ignored.
REQ-006 Port txd  output  1  UART serial out, 8N1, LSB first, idle high.
REQ-007 Port busy  output  1  high while a key event is being serialized.
REQ-008 Port byte_done  output  1  one-cycle pulse on the last clock of each stop bit.

Function
REQ-009 Key-to-code map (hex), bits 0-30 in order: 15,1D,24,2D,2C,1C,1B,23,2B,34,1A,22,21,2A,32,16,1E,26,25,2E,36,3D,3E,46,45,12,59,14,11,29,5A.
REQ-010 Block SHALL hold a 31-bit snapshot register prev[30:0] of the last reported key state.
REQ-011 Bit period SHALL be CLK_HZ/BAUD clocks, integer division (234 at defaults); every bit, including start and stop, lasts exactly one bit period.
REQ-012 FSM states: SCAN, PREFIX, CODE; SCAN is the only state with busy low.
REQ-013 SCAN: a 5-bit index examines one key per clock, 0..30, wrapping 30 -> 0.
REQ-014 SCAN: if keys[i] == prev[i], index advances; if they differ, prev[i] <= keys[i], code latched, index advances, and the FSM goes to CODE (press) or, release with BREAK_CODE_EN defined, to PREFIX.
REQ-015 PREFIX serializes byte F0, then goes to CODE; CODE serializes the latched code, then returns to SCAN.
REQ-016 Start bit (txd low) SHALL begin on the clock after the change is detected; latency from detection to falling txd edge is 1 clock.
REQ-017 Between PREFIX stop bit and CODE start bit there SHALL be zero idle clocks.
REQ-018 keys changes during busy are not queued; they are detected when the scan reaches that bit, and a press+release both inside the busy window SHALL produce no report.
REQ-019 Several simultaneous changes SHALL be reported one event at a time in ascending index order from the current scan position.
REQ-020 Worst-case detection delay with busy low is 31 clocks.

Reset
REQ-021 On reset_n low, immediately and asynchronously: txd = 1, busy = 0, byte_done = 0, prev = 0, index = 0, state = SCAN, bit/baud counters = 0.
REQ-022 Reset mid-frame SHALL abort the frame; no partial byte resumes after release.
REQ-023 Keys held at reset release SHALL be reported as presses by the normal scan.

Configuration
REQ-024 Macro BREAK_CODE_EN: defined -> a release sends F0 followed by the key code (2 frames); not defined -> a release sends only the key code (1 frame, toggle semantics), and the PREFIX state SHALL be absent.

Verification
REQ-025 Reset, keys=0 for 5000 clocks -> txd stays 1, busy 0, no byte_done.
REQ-026 keys[0] 0->1 -> txd low 1 clock after detection, frame 0x15 (bits 1,0,1,0,1,0,0,0), 2340 clocks, one byte_done, busy drops.
REQ-027 BREAK_CODE_EN defined, keys[30] 1->0 -> frames F0 then 5A back-to-back, two byte_done pulses 2340 clocks apart; undefined -> single 5A frame.
REQ-028 keys[5] and keys[29] rise same clock, index at 0 -> frame 1C then frame 29, prev[5]=prev[29]=1.
REQ-029 keys[2] pulsed high for 100 clocks during a busy frame -> no 24 frame sent; keys[35] toggled -> nothing sent.
REQ-030 reset_n low at clock 1000 of a frame -> txd 1 same cycle, busy 0; after release with keys[0]=1 -> fresh 0x15 frame.
